// File: rtl/trace_emitter.sv
// trace_emitter: queues control-flow event addresses in a circular FIFO and
// emits them as one-cycle trace_valid pulses, spaced by at least GAP idle
// cycles. Optional feature macro: TRACE_DEDUP_EN (drop an accepted event
// whose address repeats the previously accepted one).
module trace_emitter #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            evt_addr,
  input  logic                   evt_valid,
  output logic                   evt_ready,
  input  logic                   enable,
  input  logic                   flush,
  output logic [31:0]            trace,
  output logic                   trace_valid,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned LW       = AW + 1;
  localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [31:0]     trace_q, trace_d;
  logic            valid_q, valid_d;
  logic            rdy_q, rdy_d;
  logic [31:0]     mem_q [DEPTH];

  logic            full;
  logic            empty;
  logic            accept;
  logic            push;
  logic            pop;
  logic            can_send;

  // Handshake: ready only out of reset, never while full or flushing
  always_comb begin
    full      = (level_q == LW'(DEPTH));
    empty     = (level_q == '0);
    evt_ready = rdy_q && !full && !flush;
    accept    = evt_valid && evt_ready;
    can_send  = enable && !empty;
  end

`ifdef TRACE_DEDUP_EN
  logic [31:0] last_addr_q, last_addr_d;
  logic        last_vld_q, last_vld_d;

  // Remember the last accepted address; forgotten on flush
  always_comb begin
    last_addr_d = last_addr_q;
    last_vld_d  = last_vld_q;
    push        = accept && !(last_vld_q && (last_addr_q == evt_addr));
    if (flush) begin
      last_vld_d = 1'b0;
    end else if (accept) begin
      last_addr_d = evt_addr;
      last_vld_d  = 1'b1;
    end
  end

  // Comparison register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      last_vld_q  <= last_vld_d;
    end
  end
`else
  // Every accepted event is written
  always_comb begin
    push = accept;
  end
`endif

  // Emission FSM and FIFO bookkeeping. The GAP state's final cycle may launch
  // the next SEND directly so that pulses sit exactly GAP idle cycles apart.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    pop      = 1'b0;
    trace_d  = trace_q;
    valid_d  = 1'b0;
    rdy_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (can_send) begin
          state_d = S_SEND;
          pop     = 1'b1;
        end
      end
      S_SEND: begin
        if (GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GW'(GAP_LOAD);
        end else if (can_send) begin
          state_d = S_SEND;
          pop     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          if (can_send) begin
            state_d = S_SEND;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      trace_d = mem_q[rd_ptr_q];
      valid_d = 1'b1;
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);

    // Flush wins over any same-cycle push or pop; trace keeps its last value
    if (flush) begin
      state_d  = S_IDLE;
      gap_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
      trace_d  = trace_q;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      gap_q    <= '0;
      trace_q  <= '0;
      valid_q  <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      gap_q    <= gap_d;
      trace_q  <= trace_d;
      valid_q  <= valid_d;
      rdy_q    <= rdy_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= evt_addr;
    end
  end

  // Registered outputs
  always_comb begin
    trace       = trace_q;
    trace_valid = valid_q;
    fifo_level  = level_q;
  end

endmodule

// File: tb/tb_trace_emitter.sv
// Testbench for trace_emitter: directed scenarios plus randomized traffic,
// checked by a queue-based scoreboard and a GAP=3 spacing instance.
module tb_trace_emitter;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   evt_addr;
  logic          evt_valid;
  logic          evt_ready;
  logic          enable;
  logic          flush;
  logic [31:0]   trace;
  logic          trace_valid;
  logic [LW-1:0] fifo_level;

  logic [31:0]   g_evt_addr;
  logic          g_evt_valid;
  logic          g_evt_ready;
  logic          g_enable;
  logic          g_flush;
  logic [31:0]   g_trace;
  logic          g_trace_valid;
  logic [LW-1:0] g_fifo_level;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   last_trace = 32'h0;
  logic [31:0]   last_acc   = 32'h0;
  bit            last_acc_vld = 1'b0;

  always #5 clk = ~clk;

  trace_emitter #(.DEPTH(DEPTH), .GAP(0)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .evt_addr    (evt_addr),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .enable      (enable),
    .flush       (flush),
    .trace       (trace),
    .trace_valid (trace_valid),
    .fifo_level  (fifo_level)
  );

  trace_emitter #(.DEPTH(DEPTH), .GAP(3)) u_gap (
    .clk         (clk),
    .reset       (reset),
    .evt_addr    (g_evt_addr),
    .evt_valid   (g_evt_valid),
    .evt_ready   (g_evt_ready),
    .enable      (g_enable),
    .flush       (g_flush),
    .trace       (g_trace),
    .trace_valid (g_trace_valid),
    .fifo_level  (g_fifo_level)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] a);
    int k;
    k = 0;
    evt_valid = 1'b1;
    evt_addr  = a;
    while (!evt_ready && k < 100) begin
      step();
      k++;
    end
    if (!evt_ready) chk("push_timeout", 32'(evt_ready), 32'd1);
    step();
    evt_valid = 1'b0;
  endtask

  // Scoreboard monitor: reference model is an in-order queue of accepted
  // (and, with dedup, non-repeating) addresses; every pulse pops the head.
  initial begin
    logic        acc;
    logic [31:0] a;
    logic        fl;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      acc = reset && evt_valid && evt_ready;
      a   = evt_addr;
      fl  = flush;
      @(posedge clk);
      #1;
      if (!reset) begin
        exp_q.delete();
        last_acc_vld = 1'b0;
        last_trace   = 32'h0;
      end else begin
        if (fl) begin
          chk("flush_no_pulse", 32'(trace_valid), 32'd0);
          exp_q.delete();
          last_acc_vld = 1'b0;
        end else begin
          if (trace_valid) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_pulse_queue_size", 32'(exp_q.size()), 32'd1);
              last_trace = trace;
            end else begin
              e = exp_q.pop_front();
              chk("trace_value", trace, e);
              last_trace = e;
            end
          end
          if (acc) begin
`ifdef TRACE_DEDUP_EN
            if (!(last_acc_vld && last_acc == a)) exp_q.push_back(a);
`else
            exp_q.push_back(a);
`endif
            last_acc     = a;
            last_acc_vld = 1'b1;
          end
        end
        if (!trace_valid) chk("trace_hold", trace, last_trace);
        chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      end
    end
  end

  // Directed and random stimulus
  initial begin
    int          cnt;
    int          k;
    int          pulse_cyc[$];
    logic [31:0] gexp;

    reset = 1'b0; evt_addr = '0; evt_valid = 1'b0; enable = 1'b0; flush = 1'b0;
    g_evt_addr = '0; g_evt_valid = 1'b0; g_enable = 1'b0; g_flush = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_trace", trace, 32'h0);
    chk("rst_trace_valid", 32'(trace_valid), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_evt_ready", 32'(evt_ready), 32'd0);
    reset = 1'b1;
    step();
    chk("ready_after_reset", 32'(evt_ready), 32'd1);

    // Single event latency
    enable = 1'b1; evt_valid = 1'b1; evt_addr = 32'h0000_1000;
    step();
    evt_valid = 1'b0;
    chk("lat_n1_valid", 32'(trace_valid), 32'd0);
    chk("lat_n1_level", 32'(fifo_level), 32'd1);
    step();
    chk("lat_n2_valid", 32'(trace_valid), 32'd1);
    chk("lat_n2_trace", trace, 32'h0000_1000);
    chk("lat_n2_level", 32'(fifo_level), 32'd0);
    step();
    chk("lat_n3_valid", 32'(trace_valid), 32'd0);
    chk("lat_n3_hold", trace, 32'h0000_1000);

    // Fill to full with emission disabled, ninth held, then burst
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h3000 + 32'(i));
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_ready", 32'(evt_ready), 32'd0);
    evt_valid = 1'b1; evt_addr = 32'h3008;
    step(); step();
    chk("full_held_level", 32'(fifo_level), 32'd8);
    chk("full_held_ready", 32'(evt_ready), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 1) evt_valid = 1'b0;
      chk("b2b_valid", 32'(trace_valid), 32'd1);
    end
    step();
    chk("b2b_end_valid", 32'(trace_valid), 32'd0);
    chk("b2b_end_level", 32'(fifo_level), 32'd0);

    // Flush with simultaneous evt_valid
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h4000 + 32'(i));
    chk("pre_flush_level", 32'(fifo_level), 32'd4);
    flush = 1'b1; evt_valid = 1'b1; evt_addr = 32'h4444;
    #1;
    chk("flush_blocks_ready", 32'(evt_ready), 32'd0);
    step();
    flush = 1'b0; evt_valid = 1'b0;
    chk("post_flush_level", 32'(fifo_level), 32'd0);
    chk("post_flush_valid", 32'(trace_valid), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_flush_quiet", 32'(trace_valid), 32'd0);
    end

    // Duplicate suppression: A, A, B, A
    enable = 1'b0;
    push(32'h5A); push(32'h5A); push(32'h5B); push(32'h5A);
`ifdef TRACE_DEDUP_EN
    chk("dedup_level", 32'(fifo_level), 32'd3);
`else
    chk("dedup_level", 32'(fifo_level), 32'd4);
`endif
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (trace_valid) cnt++;
    end
`ifdef TRACE_DEDUP_EN
    chk("dedup_pulses", 32'(cnt), 32'd3);
`else
    chk("dedup_pulses", 32'(cnt), 32'd4);
`endif

    // Reset while a SEND is about to launch with 5 queued
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h6000 + 32'(i));
    enable = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(trace_valid), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_ready", 32'(evt_ready), 32'd0);
    chk("mid_rst_trace", trace, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_quiet", 32'(trace_valid), 32'd0);
    end
    push(32'h6666);
    repeat (4) step();
    chk("post_rst_drain", 32'(fifo_level), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      evt_valid = 1'($urandom_range(0, 1));
      evt_addr  = 32'h100 + 32'($urandom_range(0, 3)) * 32'h10;
      enable    = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    evt_valid = 1'b0; flush = 1'b0; enable = 1'b1;
    k = 0;
    while (fifo_level != '0 && k < 100) begin
      step();
      k++;
    end
    chk("drain_done", 32'(fifo_level), 32'd0);
    repeat (3) step();
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);

    // GAP=3 instance: three queued events, pulses exactly 4 cycles apart
    g_evt_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      g_evt_addr = 32'h2000 + 32'(i) * 32'd4;
      step();
    end
    g_evt_valid = 1'b0;
    chk("gap_level", 32'(g_fifo_level), 32'd3);
    g_enable = 1'b1;
    for (int c = 0; c < 25; c++) begin
      step();
      if (g_trace_valid) begin
        gexp = 32'h2000 + 32'(pulse_cyc.size()) * 32'd4;
        chk("gap_trace", g_trace, gexp);
        pulse_cyc.push_back(c);
      end
    end
    chk("gap_pulse_count", 32'(pulse_cyc.size()), 32'd3);
    if (pulse_cyc.size() == 3) begin
      chk("gap_spacing_1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd4);
      chk("gap_spacing_2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd4);
    end
    chk("gap_level_end", 32'(g_fifo_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
